bp_fe_mock_be_trace_checker: RTL and testbench

//  Parametrised successor to the FE mock back-end. Replays a trace ROM to drive FE commands
//  and check FE queue entries. Adds masked compares, per-entry receive timeouts,

---
 rtl/bp_fe_mock_be_trace_checker.sv | 163 ++++++++++++++++
 tb/tb_bp_fe_mock_be_trace_checker.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_mock_be_trace_checker.sv
// Trace-ROM driven mock back-end for the FE: issues FE commands, checks FE queue entries under a
// compare mask, with receive timeouts, LFSR backpressure, wait ops and a saturating error count.
module bp_fe_mock_be_trace_checker #(
    parameter int unsigned fe_cmd_width_p   = 160,
    parameter int unsigned fe_queue_width_p = 160,
    parameter int unsigned payload_width_p  = 160,
    parameter int unsigned rom_addr_width_p = 10,
    parameter int unsigned timeout_p        = 1024,
    parameter int unsigned stall_mode_p     = 0,
    parameter logic [15:0] lfsr_seed_p      = 16'hACE1,
    parameter int unsigned err_cnt_width_p  = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    output logic [rom_addr_width_p-1:0]   rom_addr_o,
    input  logic [4+payload_width_p-1:0]  rom_data_i,
    output logic [fe_cmd_width_p-1:0]     fe_cmd_o,
    output logic                          fe_cmd_v_o,
    input  logic                          fe_cmd_yumi_i,
    input  logic [fe_queue_width_p-1:0]   fe_queue_i,
    input  logic                          fe_queue_v_i,
    output logic                          fe_queue_ready_o,
    output logic                          done_o,
    output logic                          error_o,
    output logic [err_cnt_width_p-1:0]    error_cnt_o
);

    localparam int unsigned TimerW = (timeout_p > 1) ? $clog2(timeout_p) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(timeout_p - 1);

    localparam logic [3:0] OpNop    = 4'd0;
    localparam logic [3:0] OpSend   = 4'd1;
    localparam logic [3:0] OpRecv   = 4'd2;
    localparam logic [3:0] OpWait   = 4'd3;
    localparam logic [3:0] OpMask   = 4'd4;
    localparam logic [3:0] OpFinish = 4'd5;

    typedef enum logic [2:0] {StFetch, StSend, StRecv, StWait, StDone} state_e;

    state_e                        state_q, state_d;
    logic [rom_addr_width_p-1:0]   addr_q, addr_d;
    logic [payload_width_p-1:0]    payload_q, payload_d;
    logic [fe_queue_width_p-1:0]   mask_q, mask_d;
    logic [15:0]                   lfsr_q, lfsr_d;
    logic [TimerW-1:0]             timer_q, timer_d;
    logic [15:0]                   cnt_q, cnt_d;
    logic                          error_q;
    logic [err_cnt_width_p-1:0]    err_cnt_q;
    logic                          err_event;
    logic                          queue_ready;
    logic [3:0]                    rom_op;
    logic [payload_width_p-1:0]    rom_payload;
    logic [rom_addr_width_p-1:0]   addr_inc;

    assign rom_op      = rom_data_i[payload_width_p +: 4];
    assign rom_payload = rom_data_i[payload_width_p-1:0];
    assign addr_inc    = addr_q + rom_addr_width_p'(1);

    // Outputs depend only on registered state, never on the fe_* inputs.
    assign queue_ready      = (state_q == StRecv) && ((stall_mode_p == 0) || lfsr_q[0]);
    assign fe_queue_ready_o = queue_ready;
    assign fe_cmd_v_o       = (state_q == StSend);
    assign fe_cmd_o         = payload_q[fe_cmd_width_p-1:0];
    assign rom_addr_o       = addr_q;
    assign done_o           = (state_q == StDone);
    assign error_o          = error_q;
    assign error_cnt_o      = err_cnt_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        payload_d = payload_q;
        mask_d    = mask_q;
        lfsr_d    = lfsr_q;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        err_event = 1'b0;
        unique case (state_q)
            StFetch: begin
                payload_d = rom_payload;
                case (rom_op)
                    OpNop:  addr_d = addr_inc;
                    OpSend: state_d = StSend;
                    OpRecv: begin
                        state_d = StRecv;
                        timer_d = '0;
                    end
                    OpWait: begin
                        state_d = StWait;
                        cnt_d   = rom_payload[15:0];
                    end
                    OpMask: begin
                        mask_d = rom_payload[fe_queue_width_p-1:0];
                        addr_d = addr_inc;
                    end
                    OpFinish: state_d = StDone;
                    default: begin
                        err_event = 1'b1;
                        addr_d    = addr_inc;
                    end
                endcase
            end
            StSend: begin
                if (fe_cmd_yumi_i) begin
                    addr_d  = addr_inc;
                    state_d = StFetch;
                end
            end
            StRecv: begin
                lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
                // A handshake on the final timer cycle wins over the timeout.
                if (fe_queue_v_i && queue_ready) begin
                    err_event = |((fe_queue_i ^ payload_q[fe_queue_width_p-1:0]) & mask_q);
                    addr_d    = addr_inc;
                    state_d   = StFetch;
                end else if (timer_q == TimerLast) begin
                    err_event = 1'b1;
                    addr_d    = addr_inc;
                    state_d   = StFetch;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StWait: begin
                if (cnt_q == 16'd0) begin
                    addr_d  = addr_inc;
                    state_d = StFetch;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StDone: ;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StFetch;
            addr_q    <= '0;
            payload_q <= '0;
            mask_q    <= '1;
            lfsr_q    <= lfsr_seed_p;
            timer_q   <= '0;
            cnt_q     <= '0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            payload_q <= payload_d;
            mask_q    <= mask_d;
            lfsr_q    <= lfsr_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            if (err_event) begin
                error_q <= 1'b1;
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + err_cnt_width_p'(1);
            end
        end
    end

endmodule

// File: tb/tb_bp_fe_mock_be_trace_checker.sv
// Directed bench: dut0 runs without backpressure, dut1 uses LFSR stalls and a 2-bit error count.
module tb_bp_fe_mock_be_trace_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [19:0] rom0 [128];
    logic [19:0] rom1 [128];

    logic [6:0]  rom_addr0, rom_addr1;
    logic [19:0] rom_data0, rom_data1;
    logic [15:0] fe_cmd0, fe_cmd1;
    logic        fe_cmd_v0, fe_cmd_v1;
    logic        yumi0 = 1'b0, yumi1 = 1'b0;
    logic [15:0] q0 = '0, q1;
    logic        q0_v = 1'b0, q1_v = 1'b0;
    logic        ready0, ready1, done0, done1, error0, error1;
    logic [7:0]  err_cnt0;
    logic [1:0]  err_cnt1;

    assign rom_data0 = rom0[rom_addr0];
    assign rom_data1 = rom1[rom_addr1];
    assign q1        = rom1[rom_addr1][15:0];

    bp_fe_mock_be_trace_checker #(
        .fe_cmd_width_p(16), .fe_queue_width_p(16), .payload_width_p(16),
        .rom_addr_width_p(7), .timeout_p(16), .stall_mode_p(0),
        .lfsr_seed_p(16'hACE1), .err_cnt_width_p(8)
    ) dut0 (
        .clk_i(clk), .reset_i(rst), .rom_addr_o(rom_addr0), .rom_data_i(rom_data0),
        .fe_cmd_o(fe_cmd0), .fe_cmd_v_o(fe_cmd_v0), .fe_cmd_yumi_i(yumi0),
        .fe_queue_i(q0), .fe_queue_v_i(q0_v), .fe_queue_ready_o(ready0),
        .done_o(done0), .error_o(error0), .error_cnt_o(err_cnt0)
    );

    bp_fe_mock_be_trace_checker #(
        .fe_cmd_width_p(16), .fe_queue_width_p(16), .payload_width_p(16),
        .rom_addr_width_p(7), .timeout_p(16), .stall_mode_p(1),
        .lfsr_seed_p(16'hACE1), .err_cnt_width_p(2)
    ) dut1 (
        .clk_i(clk), .reset_i(rst), .rom_addr_o(rom_addr1), .rom_data_i(rom_data1),
        .fe_cmd_o(fe_cmd1), .fe_cmd_v_o(fe_cmd_v1), .fe_cmd_yumi_i(yumi1),
        .fe_queue_i(q1), .fe_queue_v_i(q1_v), .fe_queue_ready_o(ready1),
        .done_o(done1), .error_o(error1), .error_cnt_o(err_cnt1)
    );

    function automatic logic [19:0] ent(input logic [3:0] op, input logic [15:0] p);
        return {op, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted with both ROMs filled with FINISH; caller loads entries then releases.
    task automatic hold_reset();
        rst = 1'b1;
        yumi0 = 1'b0; yumi1 = 1'b0; q0_v = 1'b0; q1_v = 1'b0; q0 = '0;
        for (int i = 0; i < 128; i++) begin
            rom0[i] = ent(4'd5, 16'h0);
            rom1[i] = ent(4'd5, 16'h0);
        end
        tick();
    endtask

    task automatic test_reset();
        hold_reset();
        checks++;
        if ({fe_cmd_v0, ready0, done0, error0} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 0000", {fe_cmd_v0, ready0, done0, error0});
        end
        checks++;
        if (err_cnt0 !== 8'd0 || rom_addr0 !== 7'd0) begin
            failures++;
            $display("FAIL reset_cnt_addr: got cnt=%0d addr=%0d want 0 0", err_cnt0, rom_addr0);
        end
    endtask

    task automatic test_send_recv();
        int yumis = 0;
        hold_reset();
        rom0[0] = ent(4'd1, 16'h00A5);
        rom0[1] = ent(4'd2, 16'h00A5);
        rom0[2] = ent(4'd5, 16'h0);
        rst = 1'b0;
        for (int i = 0; i < 10 && !fe_cmd_v0; i++) tick();
        checks++;
        if (fe_cmd_v0 !== 1'b1 || fe_cmd0 !== 16'h00A5) begin
            failures++;
            $display("FAIL send_cmd: got v=%b cmd=%h want v=1 cmd=00a5", fe_cmd_v0, fe_cmd0);
        end
        tick();
        checks++;
        if (fe_cmd_v0 !== 1'b1 || fe_cmd0 !== 16'h00A5) begin
            failures++;
            $display("FAIL send_hold: got v=%b cmd=%h want v=1 cmd=00a5", fe_cmd_v0, fe_cmd0);
        end
        yumi0 = 1'b1;
        if (fe_cmd_v0) yumis++;
        tick();
        yumi0 = 1'b0;
        checks++;
        if (fe_cmd_v0 !== 1'b0 || yumis != 1) begin
            failures++;
            $display("FAIL send_yumi: got v=%b yumis=%0d want v=0 yumis=1", fe_cmd_v0, yumis);
        end
        for (int i = 0; i < 10 && !ready0; i++) tick();
        tick();
        tick();
        checks++;
        if (ready0 !== 1'b1 || fe_cmd_v0 !== 1'b0) begin
            failures++;
            $display("FAIL recv_ready: got ready=%b v=%b want 1 0", ready0, fe_cmd_v0);
        end
        q0 = 16'h00A5;
        q0_v = 1'b1;
        tick();
        q0_v = 1'b0;
        for (int i = 0; i < 10 && !done0; i++) tick();
        checks++;
        if (done0 !== 1'b1 || err_cnt0 !== 8'd0 || error0 !== 1'b0) begin
            failures++;
            $display("FAIL echo_done: got done=%b cnt=%0d err=%b want 1 0 0", done0, err_cnt0,
                     error0);
        end
        checks++;
        if (fe_cmd_v0 !== 1'b0 || ready0 !== 1'b0) begin
            failures++;
            $display("FAIL done_quiet: got v=%b ready=%b want 0 0", fe_cmd_v0, ready0);
        end
    endtask

    task automatic test_mask();
        logic [15:0] exp_entry [3];
        logic [7:0]  exp_cnt [3];
        exp_entry[0] = 16'h002F; exp_entry[1] = 16'h0020; exp_entry[2] = 16'h0056;
        exp_cnt[0] = 8'd0; exp_cnt[1] = 8'd0; exp_cnt[2] = 8'd1;
        hold_reset();
        rom0[0] = ent(4'd4, 16'h000F);
        rom0[1] = ent(4'd2, 16'h001F);
        rom0[2] = ent(4'd2, 16'h0010);
        rom0[3] = ent(4'd4, 16'hFFFF);
        rom0[4] = ent(4'd2, 16'h0055);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10 && !ready0; i++) tick();
            q0 = exp_entry[k];
            q0_v = 1'b1;
            tick();
            q0_v = 1'b0;
            checks++;
            if (err_cnt0 !== exp_cnt[k]) begin
                failures++;
                $display("FAIL mask_recv%0d: got cnt=%0d want %0d", k, err_cnt0, exp_cnt[k]);
            end
        end
        for (int i = 0; i < 10 && !done0; i++) tick();
        checks++;
        if (done0 !== 1'b1 || error0 !== 1'b1 || err_cnt0 !== 8'd1) begin
            failures++;
            $display("FAIL mask_final: got done=%b err=%b cnt=%0d want 1 1 1", done0, error0,
                     err_cnt0);
        end
    endtask

    task automatic test_timeout();
        hold_reset();
        rom0[0] = ent(4'd2, 16'h1234);
        rom0[1] = ent(4'd2, 16'h4321);
        rst = 1'b0;
        for (int i = 0; i < 10 && !ready0; i++) tick();
        repeat (15) tick();
        checks++;
        if (ready0 !== 1'b1 || err_cnt0 !== 8'd0) begin
            failures++;
            $display("FAIL timeout_early: got ready=%b cnt=%0d want 1 0", ready0, err_cnt0);
        end
        tick();
        checks++;
        if (ready0 !== 1'b0 || err_cnt0 !== 8'd1) begin
            failures++;
            $display("FAIL timeout_hit: got ready=%b cnt=%0d want 0 1", ready0, err_cnt0);
        end
        for (int i = 0; i < 10 && !ready0; i++) tick();
        repeat (15) tick();
        q0 = 16'h4321;
        q0_v = 1'b1;
        tick();
        q0_v = 1'b0;
        checks++;
        if (ready0 !== 1'b0 || err_cnt0 !== 8'd1) begin
            failures++;
            $display("FAIL timeout_last_hs: got ready=%b cnt=%0d want 0 1", ready0, err_cnt0);
        end
        for (int i = 0; i < 10 && !done0; i++) tick();
        checks++;
        if (done0 !== 1'b1 || err_cnt0 !== 8'd1) begin
            failures++;
            $display("FAIL timeout_done: got done=%b cnt=%0d want 1 1", done0, err_cnt0);
        end
    endtask

    task automatic test_stall_lfsr();
        logic [15:0] lfsr_m = 16'hACE1;
        logic        in_recv = 1'b0;
        logic        exp_ready;
        int          n = 0, recv_cycles = 0, hi = 0;
        bit          bad = 1'b0;
        hold_reset();
        for (int i = 0; i < 100; i++) rom1[i] = ent(4'd2, 16'(i * 37 + 5));
        rst = 1'b0;
        q1_v = 1'b1;
        for (int c = 0; c < 2000 && n < 100 && !bad; c++) begin
            exp_ready = in_recv & lfsr_m[0];
            checks++;
            if (ready1 !== exp_ready) begin
                failures++;
                bad = 1'b1;
                $display("FAIL stall_ready cyc%0d: got %b want %b", c, ready1, exp_ready);
            end
            if (ready1 === 1'b1) hi++;
            if (in_recv) begin
                recv_cycles++;
                if (lfsr_m[0]) begin
                    n++;
                    in_recv = 1'b0;
                end
                lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
            end else begin
                in_recv = 1'b1;
            end
            tick();
        end
        tick();
        q1_v = 1'b0;
        checks++;
        if (done1 !== 1'b1 || err_cnt1 !== 2'd0 || hi != 100) begin
            failures++;
            $display("FAIL stall_done: got done=%b cnt=%0d hi=%0d want 1 0 100", done1, err_cnt1,
                     hi);
        end
        checks++;
        if (recv_cycles == 0 || hi * 100 / recv_cycles < 30 || hi * 100 / recv_cycles > 70) begin
            failures++;
            $display("FAIL stall_duty: got hi=%0d of %0d want 30-70%%", hi, recv_cycles);
        end
    endtask

    task automatic test_wait_illegal();
        hold_reset();
        rom0[0] = ent(4'd3, 16'd0);
        rom0[1] = ent(4'd3, 16'd5);
        rom0[2] = ent(4'hF, 16'h0);
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (rom_addr0 !== 7'd1) begin
            failures++;
            $display("FAIL wait0: got addr=%0d want 1", rom_addr0);
        end
        repeat (6) tick();
        checks++;
        if (rom_addr0 !== 7'd1) begin
            failures++;
            $display("FAIL wait5_busy: got addr=%0d want 1", rom_addr0);
        end
        tick();
        checks++;
        if (rom_addr0 !== 7'd2) begin
            failures++;
            $display("FAIL wait5_exit: got addr=%0d want 2", rom_addr0);
        end
        tick();
        checks++;
        if (rom_addr0 !== 7'd3 || err_cnt0 !== 8'd1 || error0 !== 1'b1) begin
            failures++;
            $display("FAIL illegal_op: got addr=%0d cnt=%0d err=%b want 3 1 1", rom_addr0,
                     err_cnt0, error0);
        end
        tick();
        checks++;
        if (done0 !== 1'b1) begin
            failures++;
            $display("FAIL illegal_continue: got done=%b want 1", done0);
        end
    endtask

    task automatic test_reset_midop();
        hold_reset();
        rom0[0] = ent(4'd1, 16'h1111);
        rom0[1] = ent(4'd3, 16'd100);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (fe_cmd_v0 !== 1'b0 || rom_addr0 !== 7'd0) begin
            failures++;
            $display("FAIL reset_mid_send: got v=%b addr=%0d want 0 0", fe_cmd_v0, rom_addr0);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (fe_cmd_v0 !== 1'b1 || rom_addr0 !== 7'd0) begin
            failures++;
            $display("FAIL restart_send: got v=%b addr=%0d want 1 0", fe_cmd_v0, rom_addr0);
        end
        yumi0 = 1'b1;
        tick();
        yumi0 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({fe_cmd_v0, ready0, done0, error0} !== 4'b0000 || rom_addr0 !== 7'd0) begin
            failures++;
            $display("FAIL reset_mid_wait: got flags=%b addr=%0d want 0000 0",
                     {fe_cmd_v0, ready0, done0, error0}, rom_addr0);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (fe_cmd_v0 !== 1'b1 || fe_cmd0 !== 16'h1111) begin
            failures++;
            $display("FAIL replay_restart: got v=%b cmd=%h want 1 1111", fe_cmd_v0, fe_cmd0);
        end
    endtask

    task automatic test_err_saturate();
        hold_reset();
        rom1[0] = ent(4'd6, 16'h0);
        rom1[1] = ent(4'd7, 16'h0);
        rom1[2] = ent(4'd8, 16'h0);
        rom1[3] = ent(4'd9, 16'h0);
        rom1[4] = ent(4'hF, 16'h0);
        rst = 1'b0;
        repeat (4) tick();
        checks++;
        if (err_cnt1 !== 2'd3) begin
            failures++;
            $display("FAIL sat_four: got cnt=%0d want 3", err_cnt1);
        end
        tick();
        tick();
        checks++;
        if (err_cnt1 !== 2'd3 || error1 !== 1'b1 || done1 !== 1'b1) begin
            failures++;
            $display("FAIL sat_five: got cnt=%0d err=%b done=%b want 3 1 1", err_cnt1, error1,
                     done1);
        end
    endtask

    initial begin
        test_reset();
        test_send_recv();
        test_mask();
        test_timeout();
        test_stall_lfsr();
        test_wait_illegal();
        test_reset_midop();
        test_err_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
